sync_fifo_flex: RTL

Parametrised single-clock FIFO and successor to the dual-clock FIFO used between the UART and the ALU/register-file paths. It is used where producer and consumer share a clock, so no pointer synchronisers are needed. Over the earlier FIFO it adds a selectable read mode (registered or first-word-fall-through), a fill count, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.

---
 rtl/sync_fifo_flex_if.sv | 30 +++
 rtl/sync_fifo_flex.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex_if.sv
// Handshake/status bundle for sync_fifo_flex: the master side pushes/pops,
// the slave side is the FIFO itself.
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  flush;
  logic                  clr_err;
  logic                  w_inc;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  r_inc;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, w_inc, wr_data, r_inc,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, w_inc, wr_data, r_inc,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with registered or first-word-fall-through read, fill count,
// almost-full/empty thresholds, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_flex_if.slave bus
);
  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] AF_CNT  = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT  = AE_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, cnt;
  logic [ADDR_WIDTH:0] wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
  logic full_q, empty_q, af_q, ae_q, ov_q, un_q;
  logic full_nxt, empty_nxt, af_nxt, ae_nxt, ov_nxt, un_nxt;
  logic do_push, do_pop;

  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign do_pop  = bus.r_inc && !empty_q;
  assign do_push = bus.w_inc && (!full_q || do_pop);

  // Next-state pointers, count, flags and sticky errors.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    ov_nxt     = ov_q;
    un_nxt     = un_q;
    if (bus.flush) begin
      wr_ptr_nxt = PTR_ZERO;
      rd_ptr_nxt = PTR_ZERO;
      cnt_nxt    = PTR_ZERO;
    end else begin
      if (do_push) begin
        wr_ptr_nxt = wr_ptr + PTR_ONE;
      end else begin
        wr_ptr_nxt = wr_ptr;
      end
      if (do_pop) begin
        rd_ptr_nxt = rd_ptr + PTR_ONE;
      end else begin
        rd_ptr_nxt = rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_nxt = cnt + PTR_ONE;
        2'b01:   cnt_nxt = cnt - PTR_ONE;
        default: cnt_nxt = cnt;
      endcase
      // A new error event outranks a same-cycle clear.
      if (bus.w_inc && !do_push) begin
        ov_nxt = 1'b1;
      end else if (bus.clr_err) begin
        ov_nxt = 1'b0;
      end else begin
        ov_nxt = ov_q;
      end
      if (bus.r_inc && !do_pop) begin
        un_nxt = 1'b1;
      end else if (bus.clr_err) begin
        un_nxt = 1'b0;
      end else begin
        un_nxt = un_q;
      end
    end
    full_nxt  = (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    af_nxt    = (cnt_nxt >= AF_CNT);
    ae_nxt    = (cnt_nxt <= AE_CNT);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= PTR_ZERO;
      rd_ptr  <= PTR_ZERO;
      cnt     <= PTR_ZERO;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      cnt     <= cnt_nxt;
      full_q  <= full_nxt;
      empty_q <= empty_nxt;
      af_q    <= af_nxt;
      ae_q    <= ae_nxt;
      ov_q    <= ov_nxt;
      un_q    <= un_nxt;
    end
  end

  // Storage write; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (rst && !bus.flush && do_push) begin
      mem[wr_addr] <= bus.wr_data;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_q;
      // Registered read port: loads only on an accepted pop, holds otherwise.
      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_q <= {DATA_WIDTH{1'b0}};
        end else if (!bus.flush && do_pop) begin
          rd_q <= mem[rd_addr];
        end else begin
          rd_q <= rd_q;
        end
      end
      assign bus.rd_data = rd_q;
    end else begin : g_fwft_read
      assign bus.rd_data = mem[rd_addr];
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = cnt;
  assign bus.overflow     = ov_q;
  assign bus.underflow    = un_q;
endmodule
